// File: rtl/mux_nto1_stream.sv
// N-input stream multiplexer with a one-entry registered output stage.
// The grant is either a fixed select (mode 0) or a round-robin scan
// starting at ptr (mode 1). Input to output latency is one cycle.
module mux_nto1_stream #(
  parameter int unsigned  WIDTH = 32,
  parameter int unsigned  N     = 4,
  localparam int unsigned SEL_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic               mode,
  input  logic [SEL_W-1:0]   sel,
  output logic [WIDTH-1:0]   out_data,
  output logic [SEL_W-1:0]   out_src,
  output logic               out_valid,
  input  logic               out_ready
);

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] out_src_q, out_src_d;
  logic             out_valid_q, out_valid_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;

  logic             can_accept;
  logic             grant_vld;
  logic [SEL_W-1:0] grant_idx;
  logic             xfer;
  logic [WIDTH-1:0] grant_word;
  int unsigned      cand;
  logic [N-1:0]     cand_bits;

  assign can_accept = !out_valid_q || out_ready;

  // Grant selection: fixed index or first valid channel scanning from ptr with wrap.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = 0;
    cand_bits = '0;
    if (!mode) begin
      // Out-of-range select grants nothing.
      if (32'(sel) < N) begin
        grant_vld = 1'b1;
        grant_idx = sel;
      end
    end else begin
      for (int unsigned k = 0; k < N; k++) begin
        cand = 32'(ptr_q) + k;
        if (cand >= N) cand = cand - N;
        cand_bits = in_valid >> cand;
        if (!grant_vld && cand_bits[0]) begin
          grant_vld = 1'b1;
          grant_idx = SEL_W'(cand);
        end
      end
    end
  end

  // Ready is one-hot on the granted channel, gated by output register space.
  always_comb begin
    in_ready = '0;
    if (grant_vld && can_accept) in_ready = N'(1) << grant_idx;
  end

  assign xfer       = |(in_valid & in_ready);
  assign grant_word = WIDTH'(in_data >> (32'(grant_idx) * WIDTH));

  // Next state of the output register and round-robin pointer.
  always_comb begin
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    if (xfer) begin
      out_data_d  = grant_word;
      out_src_d   = grant_idx;
      out_valid_d = 1'b1;
      if (mode) begin
        ptr_d = (32'(grant_idx) == N - 1) ? '0 : grant_idx + SEL_W'(1);
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_src_q   <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_nto1_stream.sv
// Bench for mux_nto1_stream: a per-cycle reference model plus directed literal checks.
module tb_mux_nto1_stream;

  localparam int unsigned N = 4;
  localparam int unsigned W = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N*W-1:0] in_data;
  logic [N-1:0]  in_valid;
  logic [N-1:0]  in_ready;
  logic          mode;
  logic [1:0]    sel;
  logic [W-1:0]  out_data;
  logic [1:0]    out_src;
  logic          out_valid;
  logic          out_ready;

  // Second instance with N = 5 to reach out-of-range selects.
  logic [39:0]   in_data5;
  logic [4:0]    in_valid5;
  logic [4:0]    in_ready5;
  logic          mode5;
  logic [2:0]    sel5;
  logic [7:0]    out_data5;
  logic [2:0]    out_src5;
  logic          out_valid5;
  logic          out_ready5;

  int checks = 0;
  int failures = 0;

  mux_nto1_stream #(.WIDTH(W), .N(N)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mode(mode), .sel(sel), .out_data(out_data),
    .out_src(out_src), .out_valid(out_valid), .out_ready(out_ready)
  );

  mux_nto1_stream #(.WIDTH(8), .N(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data5), .in_valid(in_valid5),
    .in_ready(in_ready5), .mode(mode5), .sel(sel5), .out_data(out_data5),
    .out_src(out_src5), .out_valid(out_valid5), .out_ready(out_ready5)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: current and pending state of the output slot and pointer.
  bit          m_valid, n_valid;
  logic [31:0] m_data, n_data;
  int          m_src, n_src, m_ptr, n_ptr;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid = 0; m_data = 0; m_src = 0; m_ptr = 0;
      n_valid = 0; n_data = 0; n_src = 0; n_ptr = 0;
    end else begin
      m_valid = n_valid; m_data = n_data; m_src = n_src; m_ptr = n_ptr;
    end
  end

  // Compare every cycle mid-period, then compute what the next edge must do.
  always @(negedge clk) begin
    bit          room, gv;
    int          gi;
    logic [N-1:0] exp_ready;
    room = !m_valid || out_ready;
    gv = 0;
    gi = 0;
    if (mode == 1'b0) begin
      if (int'(sel) < N) begin gv = 1; gi = int'(sel); end
    end else begin
      for (int k = 0; k < N; k++) begin
        if (!gv && in_valid[(m_ptr + k) % N]) begin gv = 1; gi = (m_ptr + k) % N; end
      end
    end
    exp_ready = (gv && room) ? N'(1 << gi) : '0;
    chk("model_out_valid", 32'(out_valid), 32'(m_valid));
    chk("model_out_data", out_data, m_data);
    chk("model_out_src", 32'(out_src), 32'(m_src));
    chk("model_in_ready", 32'(in_ready), 32'(exp_ready));
    if (rst_n) begin
      n_valid = m_valid; n_data = m_data; n_src = m_src; n_ptr = m_ptr;
      if (gv && room && in_valid[gi]) begin
        n_valid = 1;
        n_data  = in_data[gi*W +: W];
        n_src   = gi;
        if (mode) n_ptr = (gi + 1) % N;
      end else if (out_ready) begin
        n_valid = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int rr_a[4] = '{1, 3, 1, 3};
  int rr_b[6] = '{0, 1, 2, 3, 0, 1};

  initial begin
    rst_n = 1'b0;
    mode = 1'b0; sel = 2'd2; out_ready = 1'b1; in_valid = '0;
    in_data = {32'h33333333, 32'hDEADBEEF, 32'h11111111, 32'h00000000};
    mode5 = 1'b0; sel5 = 3'd5; in_valid5 = '0; out_ready5 = 1'b1;
    in_data5 = {8'hA5, 8'h04, 8'h03, 8'h02, 8'h01};
    repeat (2) step();
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'h4);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_data", out_data, 32'h0);

    // Fixed select of channel 2.
    in_valid = 4'hF;
    #1 chk("fix_in_ready", 32'(in_ready), 32'h4);
    step();
    chk("fix_data", out_data, 32'hDEADBEEF);
    chk("fix_src", 32'(out_src), 32'd2);
    chk("fix_valid", 32'(out_valid), 32'd1);

    // Reset while holding a word.
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_data", out_data, 32'h0);
    chk("midrst_src", 32'(out_src), 32'd0);
    in_valid = '0;
    step();
    rst_n = 1'b1;
    step();
    chk("postrst_valid", 32'(out_valid), 32'd0);

    // Round robin, channels 1 and 3 only, then all four.
    mode = 1'b1;
    in_valid = 4'b1010;
    foreach (rr_a[i]) begin
      step();
      chk("rr_odd_src", 32'(out_src), 32'(rr_a[i]));
    end
    in_valid = 4'hF;
    foreach (rr_b[i]) begin
      step();
      chk("rr_all_src", 32'(out_src), 32'(rr_b[i]));
    end

    // Mode switch keeps ptr = 2.
    mode = 1'b0; sel = 2'd0;
    step(); chk("msw_fix0", 32'(out_src), 32'd0);
    step(); chk("msw_fix1", 32'(out_src), 32'd0);
    mode = 1'b1;
    step(); chk("msw_rr", 32'(out_src), 32'd2);

    // Wrap-around: ptr = 3, only channel 0 valid.
    in_valid = 4'b0001;
    step(); chk("wrap_src", 32'(out_src), 32'd0);
    in_valid = 4'hF;
    step(); chk("wrap_ptr", 32'(out_src), 32'd1);

    // Back-pressure.
    mode = 1'b0; sel = 2'd1;
    in_data[32 +: 32] = 32'h12345678;
    in_valid = 4'b0010;
    step();
    chk("bp_load", out_data, 32'h12345678);
    in_data[32 +: 32] = 32'hCAFEF00D;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 chk("bp_in_ready", 32'(in_ready), 32'h0);
      step();
      chk("bp_hold_data", out_data, 32'h12345678);
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    #1 chk("bp_release_ready", 32'(in_ready), 32'h2);
    step();
    chk("bp_next_data", out_data, 32'hCAFEF00D);
    chk("bp_next_valid", 32'(out_valid), 32'd1);
    in_valid = '0;
    step();
    chk("drain_valid", 32'(out_valid), 32'd0);
    chk("drain_hold_data", out_data, 32'hCAFEF00D);

    // N = 5: out-of-range select and top channel.
    in_valid5 = 5'h1F;
    sel5 = 3'd5;
    #1 chk("n5_sel5_ready", 32'(in_ready5), 32'h0);
    sel5 = 3'd4;
    #1 chk("n5_sel4_ready", 32'(in_ready5), 32'h10);
    step();
    chk("n5_data", 32'(out_data5), 32'hA5);
    chk("n5_src", 32'(out_src5), 32'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
